// File: rtl/total_exp_arbiter.sv
// Round-robin arbiter sharing one total-exponent datapath (te = k*2^ES + exp) among NREQ requesters.
// Latency: 1 cycle from grant to registered response slot; one result per cycle with consumer ready.
// Backpressure: no grant while the slot is full and rsp_ready_i is low; slot outputs hold stable.
module total_exp_arbiter #(
    parameter int N    = 16,
    parameter int ES   = 1,
    parameter int NREQ = 2,
    localparam int K_BITS  = $clog2(N) + 1,
    localparam int TE_BITS = K_BITS + ES,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NREQ-1:0]           req_valid_i,
    output logic [NREQ-1:0]           req_ready_o,
    input  logic [NREQ*K_BITS-1:0]    req_k_i,
    input  logic [NREQ*ES-1:0]        req_exp_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic signed [TE_BITS-1:0] rsp_te_o,
    output logic [IDW-1:0]            rsp_id_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDW-1:0]      rr_ptr;
    logic [IDW-1:0]      ptr_nxt;
    logic                can_accept;
    logic                gnt_vld;
    logic [IDW-1:0]      gnt_idx;
    int                  cand;
    logic [K_BITS-1:0]   k_sel;
    logic [ES-1:0]       exp_sel;
    logic [TE_BITS-1:0]  te_nxt;

    assign can_accept = (state == EMPTY) | rsp_ready_i;

    // Search order starts at rr_ptr and wraps, so the most recent winner goes last.
    always_comb begin
        gnt_vld     = 1'b0;
        gnt_idx     = '0;
        cand        = 0;
        req_ready_o = '0;
        if (!rst_i && can_accept) begin
            for (int i = 0; i < NREQ; i++) begin
                cand = int'(rr_ptr) + i;
                if (cand >= NREQ) begin
                    cand = cand - NREQ;
                end
                if (!gnt_vld && req_valid_i[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = IDW'(cand);
                end
            end
        end
        if (gnt_vld) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    assign k_sel   = req_k_i[int'(gnt_idx)*K_BITS +: K_BITS];
    assign exp_sel = req_exp_i[int'(gnt_idx)*ES +: ES];

    // exp < 2^ES, so k*2^ES + exp is exactly the two's-complement concatenation {k, exp}.
    assign te_nxt  = {k_sel, exp_sel};
    assign ptr_nxt = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (gnt_vld) state_nxt = FULL;
            FULL:    if (rsp_ready_i && !gnt_vld) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= EMPTY;
            rr_ptr   <= '0;
            rsp_te_o <= '0;
            rsp_id_o <= '0;
        end else begin
            state <= state_nxt;
            if (gnt_vld) begin
                rsp_te_o <= te_nxt;
                rsp_id_o <= gnt_idx;
                rr_ptr   <= ptr_nxt;
            end
        end
    end

    assign rsp_valid_o = (state == FULL);

endmodule

// File: tb/tb_total_exp_arbiter.sv
// Bench for total_exp_arbiter: instance a (NREQ=2, ES=1) and instance b (NREQ=3, ES=2),
// each shadowed by a transaction-level model plus directed literal checks.
module tb_total_exp_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // ---------------- instance a: N=16 (K_BITS=5), ES=1, NREQ=2, TE_BITS=6
    logic [1:0]        va;
    logic [1:0]        rdy_a_o;
    logic signed [4:0] ka [2];
    logic [0:0]        ea [2];
    logic [9:0]        k_a;
    logic [1:0]        e_a;
    logic              vld_a, rdy_a;
    logic signed [5:0] te_a;
    logic [0:0]        id_a;

    // ---------------- instance b: N=16 (K_BITS=5), ES=2, NREQ=3, TE_BITS=7
    logic [2:0]        vb;
    logic [2:0]        rdy_b_o;
    logic signed [4:0] kb [3];
    logic [1:0]        eb [3];
    logic [14:0]       k_b;
    logic [5:0]        e_b;
    logic              vld_b, rdy_b;
    logic signed [6:0] te_b;
    logic [1:0]        id_b;

    always_comb begin
        k_a = '0;
        e_a = '0;
        k_b = '0;
        e_b = '0;
        for (int i = 0; i < 2; i++) begin
            k_a[i*5 +: 5] = ka[i];
            e_a[i]        = ea[i];
        end
        for (int i = 0; i < 3; i++) begin
            k_b[i*5 +: 5] = kb[i];
            e_b[i*2 +: 2] = eb[i];
        end
    end

    total_exp_arbiter #(.N(16), .ES(1), .NREQ(2)) u_a (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(va), .req_ready_o(rdy_a_o),
        .req_k_i(k_a), .req_exp_i(e_a),
        .rsp_valid_o(vld_a), .rsp_ready_i(rdy_a),
        .rsp_te_o(te_a), .rsp_id_o(id_a)
    );

    total_exp_arbiter #(.N(16), .ES(2), .NREQ(3)) u_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(vb), .req_ready_o(rdy_b_o),
        .req_k_i(k_b), .req_exp_i(e_b),
        .rsp_valid_o(vld_b), .rsp_ready_i(rdy_b),
        .rsp_te_o(te_b), .rsp_id_o(id_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model helpers: first valid requester at or after ptr, cyclically; -1 if none.
    function automatic int pick(input int nreq, input int ptr, input logic [7:0] v);
        for (int i = 0; i < nreq; i++) begin
            if (v[(ptr + i) % nreq]) return (ptr + i) % nreq;
        end
        return -1;
    endfunction

    function automatic int te_of(input int k, input int e, input int es);
        return k * (1 << es) + e;
    endfunction

    // ---------------- models: slot contents and round-robin pointer as plain integers
    bit ma_full = 0;
    int ma_te = 0, ma_id = 0, ma_ptr = 0;
    bit mb_full = 0;
    int mb_te = 0, mb_id = 0, mb_ptr = 0;

    always @(posedge clk) begin
        int g;
        if (rst) begin
            ma_full = 0; ma_te = 0; ma_id = 0; ma_ptr = 0;
        end else begin
            g = (!ma_full || rdy_a) ? pick(2, ma_ptr, {6'b0, va}) : -1;
            if (g >= 0) begin
                ma_te = te_of(int'(ka[g]), int'(ea[g]), 1);
                ma_id = g;
                ma_full = 1;
                ma_ptr = (g + 1) % 2;
            end else if (rdy_a) begin
                ma_full = 0;
            end
        end
    end

    always @(posedge clk) begin
        int g;
        if (rst) begin
            mb_full = 0; mb_te = 0; mb_id = 0; mb_ptr = 0;
        end else begin
            g = (!mb_full || rdy_b) ? pick(3, mb_ptr, {5'b0, vb}) : -1;
            if (g >= 0) begin
                mb_te = te_of(int'(kb[g]), int'(eb[g]), 2);
                mb_id = g;
                mb_full = 1;
                mb_ptr = (g + 1) % 3;
            end else if (rdy_b) begin
                mb_full = 0;
            end
        end
    end

    // Per-cycle comparison against the models, away from the active edge.
    always @(negedge clk) begin
        int g;
        int exp_rdy;
        if (started) begin
            g = (rst || (ma_full && !rdy_a)) ? -1 : pick(2, ma_ptr, {6'b0, va});
            exp_rdy = (g >= 0) ? (1 << g) : 0;
            chk("model_a_ready", int'(rdy_a_o), exp_rdy);
            chk("model_a_valid", int'(vld_a), int'(ma_full));
            if (ma_full) begin
                chk("model_a_te", int'(te_a), ma_te);
                chk("model_a_id", int'(id_a), ma_id);
            end
            g = (rst || (mb_full && !rdy_b)) ? -1 : pick(3, mb_ptr, {5'b0, vb});
            exp_rdy = (g >= 0) ? (1 << g) : 0;
            chk("model_b_ready", int'(rdy_b_o), exp_rdy);
            chk("model_b_valid", int'(vld_b), int'(mb_full));
            if (mb_full) begin
                chk("model_b_te", int'(te_b), mb_te);
                chk("model_b_id", int'(id_b), mb_id);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string name, input int v, input int te, input int id, input int rdy);
        chk({name, "_valid"}, int'(vld_a), v);
        if (v != 0) begin
            chk({name, "_te"}, int'(te_a), te);
            chk({name, "_id"}, int'(id_a), id);
        end
        chk({name, "_ready"}, int'(rdy_a_o), rdy);
    endtask

    task automatic chk_b(input string name, input int v, input int te, input int id, input int rdy);
        chk({name, "_valid"}, int'(vld_b), v);
        if (v != 0) begin
            chk({name, "_te"}, int'(te_b), te);
            chk({name, "_id"}, int'(id_b), id);
        end
        chk({name, "_ready"}, int'(rdy_b_o), rdy);
    endtask

    initial begin
        ka[0] = 5'sd2;  ea[0] = 1'b1;
        ka[1] = -5'sd2; ea[1] = 1'b0;
        kb[0] = -5'sd1; eb[0] = 2'd3;
        kb[1] = 5'sd0;  eb[1] = 2'd0;
        kb[2] = 5'sd1;  eb[2] = 2'd2;
        va = 2'b11; vb = 3'b111;
        rdy_a = 1'b1; rdy_b = 1'b1;
        rst = 1'b1;

        // Reset with every requester valid
        cyc();
        started = 1'b1;
        chk("rst_a_valid", int'(vld_a), 0);
        chk("rst_a_te", int'(te_a), 0);
        chk("rst_a_id", int'(id_a), 0);
        chk("rst_a_ready", int'(rdy_a_o), 0);
        chk("rst_b_ready", int'(rdy_b_o), 0);
        cyc();
        rst = 1'b0;
        vb = 3'b000;
        #1;
        chk("first_grant_req0", int'(rdy_a_o), 1);

        // Alternating grants, one response per cycle
        cyc(); chk_a("alt0", 1, 5, 0, 2);
        cyc(); chk_a("alt1", 1, -4, 1, 1);
        cyc(); chk_a("alt2", 1, 5, 0, 2);

        // Backpressure: slot holds req0's result
        rdy_a = 1'b0;
        #1;
        chk("bp_ready_drop", int'(rdy_a_o), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); chk_a("bp_hold", 1, 5, 0, 0);
        end
        rdy_a = 1'b1;
        #1;
        chk("bp_release_ready", int'(rdy_a_o), 2);
        cyc(); chk_a("bp_refill", 1, -4, 1, 1);

        // Reset while FULL and stalled: pending result vanishes
        rdy_a = 1'b0;
        cyc(); chk_a("pre_rst", 1, -4, 1, 0);
        rst = 1'b1;
        cyc();
        chk("mid_rst_valid", int'(vld_a), 0);
        chk("mid_rst_ready", int'(rdy_a_o), 0);
        rst = 1'b0;
        va = 2'b00;
        rdy_a = 1'b1;
        cyc(); cyc();
        chk("post_rst_no_stale", int'(vld_a), 0);

        // Wrap-around with NREQ=3 and ES=2 boundary values
        vb = 3'b100;
        #1;
        chk("wrap_only_req2", int'(rdy_b_o), 4);
        cyc();
        vb = 3'b101;
        #1; chk_b("wrap_req0_first", 1, 6, 2, 1);
        cyc(); chk_b("k_m1_e3", 1, -1, 0, 4);
        cyc();
        vb = 3'b010;
        #1; chk_b("req2_again", 1, 6, 2, 2);
        cyc();
        kb[1] = 5'sd15; eb[1] = 2'd3;
        #1; chk_b("k0_e0", 1, 0, 1, 2);
        cyc();
        kb[0] = -5'sd16; eb[0] = 2'd0;
        vb = 3'b001;
        #1; chk_b("k_max", 1, 63, 1, 1);
        cyc();
        vb = 3'b000;
        #1; chk_b("k_min", 1, -64, 0, 0);
        cyc(); chk_b("b_drained", 0, 0, 0, 0);

        cyc(); cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
